// File: rtl/arbitro_pkg.sv
// Shared definitions for the arbitro_calculo block: FSM state encoding and
// default operand width / watchdog timeout.
package arbitro_pkg;

    localparam int unsigned DW_DEF      = 16;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } estado_e;

endpackage

// File: rtl/arbitro_calculo_if.sv
// Bus between the two requesting channels / datapath sequencer and the arbiter.
//   req, dato_in0, dato_in1 : channel requests and operands
//   listo, res_dp           : sequencer done flag and datapath result
//   inicio, dato_dp         : start pulse and granted operand to the datapath
//   ack, error, resultado   : completion pulse, timeout flag, captured result
//   canal_act, ocupado      : current owner and busy status
// master = requesters/datapath side, slave = arbiter side.
interface arbitro_calculo_if
    import arbitro_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
);
    logic [1:0]    req;
    logic [DW-1:0] dato_in0;
    logic [DW-1:0] dato_in1;
    logic          listo;
    logic [DW-1:0] res_dp;
    logic          inicio;
    logic [DW-1:0] dato_dp;
    logic [1:0]    ack;
    logic [DW-1:0] resultado;
    logic          canal_act;
    logic          ocupado;
    logic          error;

    modport master (
        output req, dato_in0, dato_in1, listo, res_dp,
        input  inicio, dato_dp, ack, resultado, canal_act, ocupado, error
    );

    modport slave (
        input  req, dato_in0, dato_in1, listo, res_dp,
        output inicio, dato_dp, ack, resultado, canal_act, ocupado, error
    );
endinterface

// File: rtl/arbitro_calculo_contador_wd.sv
// Watchdog counter for the WAIT state.
//   clk, reset : clock, async active-high reset
//   clear      : zero the count (used in START)
//   enable     : count one WAIT cycle
//   tc_c       : this enabled cycle brings the count to TIMEOUT
module contador_wd
    import arbitro_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);
    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturating increment so the count never wraps past TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the WAIT cycle that is the TIMEOUT-th one since START.
    assign tc_c = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/arbitro_calculo.sv
// Round-robin arbiter granting a shared calculation datapath to two channels.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of arbitro_calculo_if (requests, operands,
//                sequencer handshake, results and status)
module arbitro_calculo
    import arbitro_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    arbitro_calculo_if.slave    bus
);
    estado_e       state_q, state_d;
    logic          prio_q, prio_d;
    logic          canal_act_q, canal_act_d;
    logic [DW-1:0] dato_dp_q, dato_dp_d;
    logic [DW-1:0] resultado_q, resultado_d;
    logic          inicio_q, inicio_d;
    logic [1:0]    ack_q, ack_d;
    logic          error_q, error_d;
    logic          ocupado_q, ocupado_d;
    logic          wd_clear_c, wd_en_c, wd_tc_c;
    logic [1:0]    ack_sel_c;

    contador_wd #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear_c),
        .enable (wd_en_c),
        .tc_c   (wd_tc_c)
    );

    assign ack_sel_c = canal_act_q ? 2'b10 : 2'b01;

    // Next-state and registered-output logic; ack/error are computed on the
    // WAIT->DONE transition so they appear during the DONE cycle.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        canal_act_d = canal_act_q;
        dato_dp_d   = dato_dp_q;
        resultado_d = resultado_q;
        inicio_d    = 1'b0;
        ack_d       = 2'b00;
        error_d     = 1'b0;
        wd_clear_c  = 1'b0;
        wd_en_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    canal_act_d = (bus.req == 2'b11) ? prio_q : bus.req[1];
                    dato_dp_d   = canal_act_d ? bus.dato_in1 : bus.dato_in0;
                    inicio_d    = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                wd_clear_c = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                wd_en_c = 1'b1;
                // listo has priority over the watchdog on the terminal cycle
                if (bus.listo) begin
                    resultado_d = bus.res_dp;
                    ack_d       = ack_sel_c;
                    state_d     = DONE;
                end else if (wd_tc_c) begin
                    ack_d   = ack_sel_c;
                    error_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                prio_d  = ~canal_act_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ocupado_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            canal_act_q <= 1'b0;
            dato_dp_q   <= '0;
            resultado_q <= '0;
            inicio_q    <= 1'b0;
            ack_q       <= 2'b00;
            error_q     <= 1'b0;
            ocupado_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            canal_act_q <= canal_act_d;
            dato_dp_q   <= dato_dp_d;
            resultado_q <= resultado_d;
            inicio_q    <= inicio_d;
            ack_q       <= ack_d;
            error_q     <= error_d;
            ocupado_q   <= ocupado_d;
        end
    end

    assign bus.inicio    = inicio_q;
    assign bus.dato_dp   = dato_dp_q;
    assign bus.ack       = ack_q;
    assign bus.resultado = resultado_q;
    assign bus.canal_act = canal_act_q;
    assign bus.ocupado   = ocupado_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_arbitro_calculo.sv
// Directed self-checking bench for arbitro_calculo.
module tb_arbitro_calculo;
    localparam int unsigned DW      = 16;
    localparam int unsigned TIMEOUT = 15;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    arbitro_calculo_if #(.DW(DW)) bus ();

    arbitro_calculo #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outs(input string tag, input logic [15:0] exp_res);
        chk({tag, ".inicio"},  32'(bus.inicio),    32'(0));
        chk({tag, ".ack"},     32'(bus.ack),       32'(0));
        chk({tag, ".error"},   32'(bus.error),     32'(0));
        chk({tag, ".ocupado"}, 32'(bus.ocupado),   32'(0));
        chk({tag, ".result"},  32'(bus.resultado), 32'(exp_res));
    endtask

    // One complete transaction from IDLE back to IDLE.
    // listo_at = WAIT cycle (1-based) on which listo is driven, 0 = never.
    // drop_at  = WAIT cycle on which req is released early, 0 = never.
    task automatic run_txn(input string tag, input logic [1:0] r,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input int listo_at, input int drop_at,
                           input logic [15:0] res,
                           input logic exp_ch, input logic exp_err,
                           input logic [15:0] exp_dato, input logic [15:0] exp_res);
        int n;
        int exp_wait;
        logic [1:0] exp_ack;
        exp_ack  = exp_ch ? 2'b10 : 2'b01;
        exp_wait = (listo_at != 0) ? listo_at : int'(TIMEOUT);

        bus.req      = r;
        bus.dato_in0 = d0;
        bus.dato_in1 = d1;
        tick();
        chk({tag, ".start.inicio"},  32'(bus.inicio),    32'(1));
        chk({tag, ".start.canal"},   32'(bus.canal_act), 32'(exp_ch));
        chk({tag, ".start.dato"},    32'(bus.dato_dp),   32'(exp_dato));
        chk({tag, ".start.ocupado"}, 32'(bus.ocupado),   32'(1));
        tick();
        chk({tag, ".wait.inicio"},   32'(bus.inicio),    32'(0));

        n = 1;
        forever begin
            if (n == drop_at) bus.req = 2'b00;
            if (n == listo_at) begin
                bus.listo  = 1'b1;
                bus.res_dp = res;
            end
            tick();
            bus.listo = 1'b0;
            if (bus.ack != 2'b00) break;
            n++;
            if (n > 40) begin
                chk({tag, ".timeout_bound"}, 32'(n), 32'(exp_wait));
                break;
            end
        end

        chk({tag, ".wait_cycles"}, 32'(n),             32'(exp_wait));
        chk({tag, ".ack"},         32'(bus.ack),       32'(exp_ack));
        chk({tag, ".error"},       32'(bus.error),     32'(exp_err));
        chk({tag, ".resultado"},   32'(bus.resultado), 32'(exp_res));
        chk({tag, ".done.canal"},  32'(bus.canal_act), 32'(exp_ch));
        chk({tag, ".done.dato"},   32'(bus.dato_dp),   32'(exp_dato));
        bus.req = 2'b00;
        tick();
        chk_idle_outs({tag, ".idle"}, exp_res);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        bus.req      = 2'b00;
        bus.dato_in0 = '0;
        bus.dato_in1 = '0;
        bus.listo    = 1'b0;
        bus.res_dp   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk_idle_outs("rst", 16'h0000);
        chk("rst.canal", 32'(bus.canal_act), 32'(0));
        chk("rst.dato",  32'(bus.dato_dp),   32'(0));
        reset = 1'b0;
        tick();

        // Basic single-channel transaction, listo after 6 WAIT cycles
        run_txn("t1", 2'b01, 16'h0012, 16'h9999, 6, 0, 16'h0345,
                1'b0, 1'b0, 16'h0012, 16'h0345);

        // Reset in IDLE clears resultado and priority
        reset = 1'b1;
        #1;
        chk("rst2.result", 32'(bus.resultado), 32'(0));
        tick();
        reset = 1'b0;
        tick();

        // Both requesting: 0, then 1, then 0 again
        run_txn("t2", 2'b11, 16'h1111, 16'h2222, 3, 0, 16'h0AAA,
                1'b0, 1'b0, 16'h1111, 16'h0AAA);
        run_txn("t3", 2'b11, 16'h1111, 16'h2222, 1, 0, 16'h0BBB,
                1'b1, 1'b0, 16'h2222, 16'h0BBB);
        run_txn("t4", 2'b11, 16'h1111, 16'h2222, 2, 0, 16'h0CCC,
                1'b0, 1'b0, 16'h1111, 16'h0CCC);

        // Timeout: single req on ch0 while priority favours ch1
        run_txn("t5", 2'b01, 16'h5555, 16'h0000, 0, 0, 16'h0000,
                1'b0, 1'b1, 16'h5555, 16'h0CCC);

        // listo on the terminal watchdog cycle is a success
        run_txn("t6", 2'b10, 16'h0000, 16'h6666, int'(TIMEOUT), 0, 16'h0DDD,
                1'b1, 1'b0, 16'h6666, 16'h0DDD);

        // Spurious listo in IDLE must be ignored
        bus.listo  = 1'b1;
        bus.res_dp = 16'h0FFF;
        tick();
        bus.listo = 1'b0;
        chk_idle_outs("spur", 16'h0DDD);
        tick();
        chk("spur2.result", 32'(bus.resultado), 32'(16'h0DDD));

        // req dropped during WAIT still completes with ack
        run_txn("t7", 2'b01, 16'h7777, 16'h0000, 5, 2, 16'h0EEE,
                1'b0, 1'b0, 16'h7777, 16'h0EEE);

        // Asynchronous reset while in WAIT
        bus.req      = 2'b10;
        bus.dato_in1 = 16'h9999;
        tick();
        tick();
        tick();
        chk("t8.pre.ocupado", 32'(bus.ocupado),   32'(1));
        chk("t8.pre.canal",   32'(bus.canal_act), 32'(1));
        #3;
        reset = 1'b1;
        #1;
        chk_idle_outs("t8.async", 16'h0000);
        chk("t8.async.canal", 32'(bus.canal_act), 32'(0));
        chk("t8.async.dato",  32'(bus.dato_dp),   32'(0));
        bus.req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk_idle_outs("t8.post", 16'h0000);

        // First grant after reset: both high, priority back to ch0
        run_txn("t9", 2'b11, 16'h3333, 16'h4444, 4, 0, 16'h0123,
                1'b0, 1'b0, 16'h3333, 16'h0123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/arbitro_calculo.md
ARBITRO_CALCULO -- requirements
Module: arbitro_calculo

Interface
REQ-001 SHALL have parameter DW, default 16, meaning operand/result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning maximum WAIT cycles before abort.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  2  per-channel request; bit i = channel i; held high until ack[i].
REQ-006 SHALL have port dato_in0  input  DW  channel 0 operand, valid while req[0] high.
REQ-007 SHALL have port dato_in1  input  DW  channel 1 operand, valid while req[1] high.
REQ-008 SHALL have port listo  input  1  sequencer done flag (Band_Listo of the mux sequencer).
REQ-009 SHALL have port res_dp  input  DW  datapath result, valid when listo high.
REQ-010 SHALL have port inicio  output  1  one-cycle start pulse to the sequencer/datapath.
REQ-011 SHALL have port dato_dp  output  DW  latched operand of the granted channel.
REQ-012 SHALL have port ack  output  2  one-cycle completion pulse to the served channel.
REQ-013 SHALL have port resultado  output  DW  last captured result, held until next capture.
REQ-014 SHALL have port canal_act  output  1  channel currently owning the datapath.
REQ-015 SHALL have port ocupado  output  1  high in every state except IDLE.
REQ-016 SHALL have port error  output  1  one-cycle pulse, coincident with ack, when transaction timed out.

Function
REQ-017 SHALL implement FSM IDLE -> START -> WAIT -> DONE -> IDLE; all outputs registered.
REQ-018 IDLE: if req != 0, SHALL grant per round-robin, latch dato_inX into dato_dp, set canal_act, go START; else stay.
REQ-019 Round-robin: both req high -> grant channel prio; single req -> grant it regardless of prio; prio SHALL become ~canal_act on leaving DONE.
REQ-020 START: inicio SHALL be 1 for exactly this cycle; watchdog cleared; next state WAIT.
REQ-021 WAIT: listo=1 -> capture res_dp into resultado, go DONE; watchdog increments each WAIT cycle.
REQ-022 WAIT: watchdog == TIMEOUT and listo=0 -> go DONE with error flag set, resultado unchanged.
REQ-023 listo=1 in the same cycle watchdog reaches TIMEOUT SHALL count as success (no error).
REQ-024 DONE: ack[canal_act]=1 (other bit 0), error=flag, for exactly one cycle; next state IDLE.
REQ-025 Latency: req sampled at edge k in IDLE -> inicio high cycle k+1; listo sampled at edge m -> ack high cycle m+1.
REQ-026 listo while not in WAIT SHALL be ignored; req changes after grant SHALL NOT abort the transaction (ack still issued).
REQ-027 Requester SHALL drop req on the edge sampling ack; block need not filter a stale req.
REQ-028 dato_dp and canal_act SHALL remain stable from grant until return to IDLE.

Reset
REQ-029 reset=1 SHALL asynchronously force IDLE, prio=0, watchdog=0, inicio=0, ack=0, error=0, ocupado=0, canal_act=0, dato_dp=0, resultado=0.
REQ-030 Reset mid-transaction SHALL drop it with no ack/error; first grant after release follows REQ-018.

Structure
REQ-031 State encodings (IDLE=2'b00, START=2'b01, WAIT=2'b10, DONE=2'b11) and DW/TIMEOUT defaults SHALL live in shared package arbitro_pkg.
REQ-032 Watchdog SHALL be sub-module contador_wd (clear, enable, terminal-count output, width ceil(log2(TIMEOUT+1))).

Verification
REQ-033 req=2'b01, dato_in0=16'h0012, listo after 6 WAIT cycles with res_dp=16'h0345 -> inicio one pulse, ack=2'b01 one cycle, resultado=16'h0345, error=0.
REQ-034 req=2'b11 from reset -> channel 0 served first, then channel 1; repeat with both high -> channel 0 again after channel 1 (alternation).
REQ-035 Single req, listo never asserted -> ack pulse and error=1 after exactly TIMEOUT=15 WAIT cycles; resultado unchanged.
REQ-036 listo on the 15th WAIT cycle -> success, error=0, resultado=res_dp.
REQ-037 reset asserted during WAIT -> all outputs 0 immediately (asynchronous), no ack; new req after release served normally.
REQ-038 Spurious listo pulse in IDLE and req[0] dropped during WAIT -> no effect; ack[0] still pulses on completion.
